// File: rtl/obuf.sv
// Output buffer: collects full-width beats from the controller into an output_size-word
// buffer, then drains it one word at a time over a valid/ready handshake.
module obuf #(
    parameter int datatype_size = 8,
    parameter int xbar_size     = 256,
    parameter int output_size   = 512
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_start,
    input  logic [xbar_size-1:0][datatype_size-1:0]     i_data,
    output logic                                        o_busy,
    output logic                                        o_valid,
    output logic [datatype_size-1:0]                    o_data,
    input  logic                                        i_ready,
    output logic                                        o_done
);

    localparam int NUM_BEATS = output_size / xbar_size;
    localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int IW        = (output_size > 1) ? $clog2(output_size) : 1;

    typedef enum logic [1:0] {EMPTY, FILL, DRAIN} state_e;

    state_e                                   state_q, state_d;
    logic [BW-1:0]                            wr_beat_q, wr_beat_d;
    logic [IW-1:0]                            rd_idx_q, rd_idx_d;
    logic                                     busy_q, busy_d;
    logic                                     valid_q, valid_d;
    logic [datatype_size-1:0]                 data_q, data_d;
    logic                                     done_q, done_d;
    logic [output_size-1:0][datatype_size-1:0] mem_q;
    logic [datatype_size-1:0]                 first_word;
    logic                                     accept;

    // Beats offered while busy never reach the buffer.
    assign accept = i_start && !busy_q;

    // With a single beat the first word is still on i_data when the drain is set up.
    assign first_word = (NUM_BEATS == 1) ? i_data[0] : mem_q[0];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
                if (wr_beat_q == BW'(b))
                    mem_q[b*xbar_size +: xbar_size] <= i_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_beat_d = wr_beat_q;
        rd_idx_d  = rd_idx_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        data_d    = data_q;
        done_d    = 1'b0;
        case (state_q)
            EMPTY, FILL: begin
                if (i_start) begin
                    if (wr_beat_q == BW'(NUM_BEATS - 1)) begin
                        state_d   = DRAIN;
                        wr_beat_d = '0;
                        rd_idx_d  = '0;
                        busy_d    = 1'b1;
                        valid_d   = 1'b1;
                        data_d    = first_word;
                    end else begin
                        state_d   = FILL;
                        wr_beat_d = wr_beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_ready) begin
                    if (rd_idx_q == IW'(output_size - 1)) begin
                        state_d  = EMPTY;
                        rd_idx_d = '0;
                        busy_d   = 1'b0;
                        valid_d  = 1'b0;
                        data_d   = '0;
                        done_d   = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                        data_d   = mem_q[rd_idx_d];
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            wr_beat_q <= '0;
            rd_idx_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_beat_q <= wr_beat_d;
            rd_idx_q  <= rd_idx_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_obuf.sv
// Bench for obuf: queue-based reference model checked every cycle, plus literal
// expectations on the drained word order for each directed scenario.
module tb_obuf;
    localparam int DW = 8;
    localparam int XS = 4;
    localparam int OS = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   i_start = 1'b0;
    logic                   i_ready = 1'b1;
    logic [XS-1:0][DW-1:0]  i_data = '0;
    logic                   o_busy, o_valid, o_done;
    logic [DW-1:0]          o_data;

    always #5 clk = ~clk;

    obuf #(.datatype_size(DW), .xbar_size(XS), .output_size(OS)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data),
        .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready), .o_done(o_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words accumulate until a full buffer exists, then leave in order.
    logic [DW-1:0] m_fill[$];
    logic [DW-1:0] m_words[$];
    bit            m_drain = 1'b0;
    bit            m_done  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fill.delete();
            m_words.delete();
            m_drain = 1'b0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_drain) begin
                if (i_ready) begin
                    void'(m_words.pop_front());
                    if (m_words.size() == 0) begin
                        m_drain = 1'b0;
                        m_done  = 1'b1;
                    end
                end
            end else if (i_start) begin
                for (int k = 0; k < XS; k++) m_fill.push_back(i_data[k]);
                if (m_fill.size() == OS) begin
                    m_words = m_fill;
                    m_fill.delete();
                    m_drain = 1'b1;
                end
            end
        end
    end

    logic [DW-1:0] cap[$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        chk("busy",  32'(o_busy),  32'(m_drain));
        chk("valid", 32'(o_valid), 32'(m_drain));
        chk("data",  32'(o_data),  m_drain ? 32'(m_words[0]) : 32'h0);
        chk("done",  32'(o_done),  32'(m_done));
        if (rst && o_valid && i_ready) cap.push_back(o_data);
        if (o_done) done_cnt++;
    end

    function automatic logic [XS-1:0][DW-1:0] mk(input logic [DW-1:0] base);
        logic [XS-1:0][DW-1:0] v;
        for (int k = 0; k < XS; k++) v[k] = base + DW'(k);
        return v;
    endfunction

    task automatic send_beat(input logic [DW-1:0] base);
        @(posedge clk); #2;
        i_start = 1'b1;
        i_data  = mk(base);
    endtask

    task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] b, input int mode);
        cap.delete();
        done_cnt = 0;
        send_beat(a);
        send_beat(b);
        @(posedge clk); #2;
        if (mode == 2) begin
            i_start = 1'b1;
            i_data  = {XS{8'hFF}};
        end else begin
            i_start = 1'b0;
            i_data  = '0;
        end
        chk("busy_after_last_beat", 32'(o_busy), 32'h1);
        chk("first_word", 32'(o_data), 32'(a));
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ready high with start spam
    task automatic run_drain(input int mode);
        bit seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (o_done) begin
                seen    = 1'b1;
                i_start = 1'b0;
                i_data  = '0;
                i_ready = 1'b1;
                break;
            end
            if (mode == 1) i_ready = ((c + 1) % 4 == 0) || ((c + 1) % 4 == 3);
        end
        chk("drain_done_seen", 32'(seen), 32'h1);
        @(negedge clk); #1;
        chk("done_count", 32'(done_cnt), 32'h1);
        chk("busy_after_done", 32'(o_busy), 32'h0);
    endtask

    task automatic chk_words(input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        logic [31:0] got;
        logic [31:0] exp;
        chk("word_count", 32'(cap.size()), 32'(OS));
        for (int i = 0; i < OS; i++) begin
            exp = (i < XS) ? 32'(b0) + 32'(i) : 32'(b1) + 32'(i - XS);
            got = (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD;
            chk("word_order", got, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy",  32'(o_busy),  32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data",  32'(o_data),  32'h0);
        chk("rst_done",  32'(o_done),  32'h0);
        rst = 1'b1;

        // back-to-back fill, full-rate drain
        i_ready = 1'b1;
        fill(8'h00, 8'h10, 0);
        run_drain(0);
        chk_words(8'h00, 8'h10);

        // backpressure
        fill(8'h20, 8'h30, 1);
        run_drain(1);
        chk_words(8'h20, 8'h30);

        // start while busy, then a clean buffer
        fill(8'h40, 8'h50, 2);
        run_drain(2);
        chk_words(8'h40, 8'h50);
        fill(8'h60, 8'h70, 0);
        run_drain(0);
        chk_words(8'h60, 8'h70);

        // gapped fill
        cap.delete();
        done_cnt = 0;
        send_beat(8'hA0);
        for (int g = 0; g < 6; g++) begin
            @(posedge clk); #2;
            i_start = 1'b0;
            i_data  = '0;
            chk("gap_busy", 32'(o_busy), 32'h0);
        end
        i_start = 1'b1;
        i_data  = mk(8'hB0);
        @(posedge clk); #2;
        i_start = 1'b0;
        i_data  = '0;
        chk("gap_busy_after_beat1", 32'(o_busy), 32'h1);
        run_drain(0);
        chk_words(8'hA0, 8'hB0);

        // async reset mid-drain
        fill(8'hC0, 8'hD0, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (cap.size() >= 3) break;
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_busy",  32'(o_busy),  32'h0);
        chk("arst_valid", 32'(o_valid), 32'h0);
        chk("arst_data",  32'(o_data),  32'h0);
        chk("arst_done",  32'(o_done),  32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        chk("arst_no_done", 32'(done_cnt), 32'h0);
        fill(8'hE0, 8'hF0, 0);
        run_drain(0);
        chk_words(8'hE0, 8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
